// File: rtl/pattern_det_pkg.sv
// Shared defaults and elaboration helpers for the streaming pattern detectors.
package pattern_det_pkg;

    localparam int             DEF_PAT_LEN   = 3;
    localparam logic [2:0]     DEF_PATTERN   = 3'b010;
    localparam int             DEF_FRAME_LEN = 32;
    localparam int             DEF_CNT_W     = 4;
    localparam bit             DEF_OVERLAP   = 1'b1;

    // Never returns 0, so a counter sized from it always has at least one bit.
    function automatic int clog2_safe(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic bit params_ok(input int pat_len, input int frame_len);
        return (pat_len >= 2) && (pat_len <= 16) && (pat_len <= frame_len);
    endfunction

endpackage

// File: rtl/pattern_window.sv
// Sliding PAT_LEN-bit history with a fill counter; hit flags a completed pattern
// on the cycle the completing bit is shifted in.
module pattern_window
    import pattern_det_pkg::*;
#(
    parameter int                 PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic shift_en,
    input  logic restart,
    input  logic bit_in,
    output logic hit
);

    localparam int                FILL_W   = clog2_safe(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN);

    logic [PAT_LEN-1:0] hist_q, hist_d, shifted;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic               unused_hist_msb;

    // The oldest bit falls out on every shift; it is kept only for visibility.
    assign unused_hist_msb = hist_q[PAT_LEN-1];

    always_comb begin
        shifted = {hist_q[PAT_LEN-2:0], bit_in};
        hist_d  = hist_q;
        fill_d  = fill_q;
        // fill_q counts bits before this one, so PAT_LEN-1 already means full.
        hit     = shift_en && (fill_q >= FILL_MAX - 1'b1) && (shifted == PATTERN);
        if (clear) begin
            hist_d = '0;
            fill_d = '0;
        end else if (shift_en) begin
            hist_d = shifted;
            if (restart) begin
                fill_d = '0;
            end else if (fill_q != FILL_MAX) begin
                fill_d = fill_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/serial_pattern_counter.sv
// Serial pattern detector: per-match pulse plus a saturating match count
// reported once per FRAME_LEN accepted bits.
module serial_pattern_counter
    import pattern_det_pkg::*;
#(
    parameter int                 PAT_LEN   = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN   = DEF_PATTERN,
    parameter int                 FRAME_LEN = DEF_FRAME_LEN,
    parameter int                 CNT_W     = DEF_CNT_W,
    parameter bit                 OVERLAP   = DEF_OVERLAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             clear,
    output logic             match,
    output logic [CNT_W-1:0] count,
    output logic             count_valid,
    output logic             count_sat
);

    localparam int               IDX_W    = clog2_safe(FRAME_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    if (!params_ok(PAT_LEN, FRAME_LEN)) begin : g_bad_params
        $error("serial_pattern_counter: PAT_LEN must be 2..16 and <= FRAME_LEN");
    end

    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d, cnt_inc;
    logic             run_sat_q, run_sat_d, sat_inc;
    logic [CNT_W-1:0] count_q, count_d;
    logic             count_sat_q, count_sat_d;
    logic             count_valid_q, count_valid_d;
    logic             match_q, match_d;
    logic             accept, frame_end, restart, hit;

    // A cleared cycle never shifts, so its bit is dropped and cannot hit.
    assign accept    = bit_valid & ~clear;
    assign frame_end = accept && (bit_idx_q == LAST_IDX);
    assign restart   = frame_end | (hit & ~OVERLAP);

    pattern_window #(
        .PAT_LEN (PAT_LEN),
        .PATTERN (PATTERN)
    ) u_window (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .shift_en (accept),
        .restart  (restart),
        .bit_in   (bit_in),
        .hit      (hit)
    );

    always_comb begin
        bit_idx_d     = bit_idx_q;
        run_cnt_d     = run_cnt_q;
        run_sat_d     = run_sat_q;
        count_d       = count_q;
        count_sat_d   = count_sat_q;
        count_valid_d = 1'b0;
        match_d       = hit;
        cnt_inc       = run_cnt_q;
        sat_inc       = run_sat_q;
        // run_sat marks a match that arrived while the counter was already full.
        if (hit) begin
            if (run_cnt_q == CNT_MAX) begin
                sat_inc = 1'b1;
            end else begin
                cnt_inc = run_cnt_q + 1'b1;
            end
        end
        if (clear) begin
            bit_idx_d = '0;
            run_cnt_d = '0;
            run_sat_d = 1'b0;
        end else if (accept) begin
            if (frame_end) begin
                count_d       = cnt_inc;
                count_sat_d   = sat_inc;
                count_valid_d = 1'b1;
                bit_idx_d     = '0;
                run_cnt_d     = '0;
                run_sat_d     = 1'b0;
            end else begin
                bit_idx_d = bit_idx_q + 1'b1;
                run_cnt_d = cnt_inc;
                run_sat_d = sat_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_idx_q     <= '0;
            run_cnt_q     <= '0;
            run_sat_q     <= 1'b0;
            count_q       <= '0;
            count_sat_q   <= 1'b0;
            count_valid_q <= 1'b0;
            match_q       <= 1'b0;
        end else begin
            bit_idx_q     <= bit_idx_d;
            run_cnt_q     <= run_cnt_d;
            run_sat_q     <= run_sat_d;
            count_q       <= count_d;
            count_sat_q   <= count_sat_d;
            count_valid_q <= count_valid_d;
            match_q       <= match_d;
        end
    end

    assign match       = match_q;
    assign count       = count_q;
    assign count_valid = count_valid_q;
    assign count_sat   = count_sat_q;

endmodule

// File: tb/tb_serial_pattern_counter.sv
// Directed frame vectors driven into three configurations at once: default,
// non-overlapping, and a 3-bit counter that saturates.
module tb_serial_pattern_counter;

    logic clk = 1'b0;
    logic rst, bit_in, bit_valid, clear;

    logic       match_a, match_b, match_c;
    logic [3:0] count_a, count_b;
    logic [2:0] count_c;
    logic       cv_a_o, cv_b_o, cv_c_o;
    logic       sat_a, sat_b, sat_c;

    serial_pattern_counter dut_a (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .clear(clear),
        .match(match_a), .count(count_a), .count_valid(cv_a_o), .count_sat(sat_a)
    );
    serial_pattern_counter #(.OVERLAP(1'b0)) dut_b (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .clear(clear),
        .match(match_b), .count(count_b), .count_valid(cv_b_o), .count_sat(sat_b)
    );
    serial_pattern_counter #(.CNT_W(3)) dut_c (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .clear(clear),
        .match(match_c), .count(count_c), .count_valid(cv_c_o), .count_sat(sat_c)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] word;
        bit          gaps;
        int          cnt_a;
        int          cnt_b;
        int          cnt_c;
        bit          sat_c;
        int          pul_a;
        int          pul_b;
        int          pul_c;
    } vec_t;

    vec_t vecs[8];
    int   n_vec = 0;
    int   n_err = 0;

    // Running pulse totals, sampled away from the active edge.
    int m_a = 0, m_b = 0, m_c = 0;
    int cv_a = 0, cv_b = 0, cv_c = 0;

    always @(negedge clk) begin
        if (match_a) m_a++;
        if (match_b) m_b++;
        if (match_c) m_c++;
        if (cv_a_o) cv_a++;
        if (cv_b_o) cv_b++;
        if (cv_c_o) cv_c++;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic send_bits(input logic [31:0] word, input int nbits, input bit gaps);
        for (int i = 31; i > 31 - nbits; i--) begin
            int g;
            g = 0;
            while (gaps && g < 4 && $urandom_range(0, 1) == 1) begin
                bit_valid = 1'b0;
                @(posedge clk); #1;
                g++;
            end
            bit_valid = 1'b1;
            bit_in    = word[i];
            @(posedge clk); #1;
        end
        bit_valid = 1'b0;
    endtask

    task automatic send_frame(input vec_t v, input string tag);
        int ba, bb, bc, ca, cb, cc;
        ba = m_a; bb = m_b; bc = m_c;
        ca = cv_a; cb = cv_b; cc = cv_c;
        send_bits(v.word, 32, v.gaps);
        // One cycle after the 32nd accepted bit.
        chk({tag, " count_valid_a"}, int'(cv_a_o), 1);
        chk({tag, " count_valid_b"}, int'(cv_b_o), 1);
        chk({tag, " count_valid_c"}, int'(cv_c_o), 1);
        chk({tag, " count_a"}, int'(count_a), v.cnt_a);
        chk({tag, " count_b"}, int'(count_b), v.cnt_b);
        chk({tag, " count_c"}, int'(count_c), v.cnt_c);
        chk({tag, " count_sat_a"}, int'(sat_a), 0);
        chk({tag, " count_sat_b"}, int'(sat_b), 0);
        chk({tag, " count_sat_c"}, int'(sat_c), int'(v.sat_c));
        @(posedge clk); #1;
        chk({tag, " count_valid_a drop"}, int'(cv_a_o), 0);
        chk({tag, " pulses_a"}, m_a - ba, v.pul_a);
        chk({tag, " pulses_b"}, m_b - bb, v.pul_b);
        chk({tag, " pulses_c"}, m_c - bc, v.pul_c);
        chk({tag, " cv_once_a"}, cv_a - ca, 1);
        chk({tag, " cv_once_b"}, cv_b - cb, 1);
        chk({tag, " cv_once_c"}, cv_c - cc, 1);
    endtask

    initial begin
        int ba, ca;

        //            word          gaps  ca  cb  cc  satc  pa  pb  pc
        vecs[0] = '{32'h5555_5555, 1'b0, 15,  8,  7, 1'b1, 15,  8, 15};
        vecs[1] = '{32'hFFFF_FFFF, 1'b0,  0,  0,  0, 1'b0,  0,  0,  0};
        vecs[2] = '{32'h0000_0001, 1'b0,  0,  0,  0, 1'b0,  0,  0,  0};
        vecs[3] = '{32'h0000_0000, 1'b0,  0,  0,  0, 1'b0,  0,  0,  0};
        vecs[4] = '{32'h5555_5555, 1'b1, 15,  8,  7, 1'b1, 15,  8, 15};
        vecs[5] = '{32'h4000_0000, 1'b0,  1,  1,  1, 1'b0,  1,  1,  1};
        vecs[6] = '{32'h5000_0000, 1'b0,  2,  1,  2, 1'b0,  2,  1,  2};
        vecs[7] = '{32'hAAAA_AAAA, 1'b0, 15,  8,  7, 1'b1, 15,  8, 15};

        rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset match_a", int'(match_a), 0);
        chk("reset count_a", int'(count_a), 0);
        chk("reset count_valid_a", int'(cv_a_o), 0);
        chk("reset count_sat_c", int'(sat_c), 0);
        chk("reset count_b", int'(count_b), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            send_frame(vecs[i], $sformatf("v%0d", i));
        end

        // Clear after 20 bits, colliding with a valid bit that would complete a match.
        ba = m_a; ca = cv_a;
        send_bits(32'h5555_5555, 20, 1'b0);
        bit_valid = 1'b1; bit_in = 1'b0; clear = 1'b1;
        @(posedge clk); #1;
        bit_valid = 1'b0; clear = 1'b0;
        chk("clear match_a", int'(match_a), 0);
        chk("clear count_valid_a", int'(cv_a_o), 0);
        chk("clear count_a held", int'(count_a), 15);
        chk("clear count_c held", int'(count_c), 7);
        chk("clear count_sat_c held", int'(sat_c), 1);
        repeat (3) @(posedge clk);
        #1;
        chk("clear pulses_a", m_a - ba, 9);
        chk("clear no count_valid", cv_a - ca, 0);
        send_frame(vecs[0], "after_clear");

        // Reset in the middle of a frame.
        send_bits(32'h5555_5555, 10, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst count_a", int'(count_a), 0);
        chk("rst count_b", int'(count_b), 0);
        chk("rst count_c", int'(count_c), 0);
        chk("rst count_sat_c", int'(sat_c), 0);
        chk("rst match_a", int'(match_a), 0);
        chk("rst count_valid_a", int'(cv_a_o), 0);
        send_frame(vecs[7], "after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
